// File: rtl/counter_pkg.sv
// Shared types and constants for the increment counter.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/increment.sv
// Combinational WIDTH-bit incrementer; all-ones wraps to zero.
module increment
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = a + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/increment_counter.sv
// Up-counter run controller: counts from a captured start value to a captured
// limit, then either stops or reloads, pulsing done at each terminal count.
//
// state | meaning
// IDLE  | waiting for start; count holds its last value
// RUN   | counting while en is high; terminal count stops or reloads
module increment_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             en,
    input  logic             wrap_mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] limit_q;
    logic             wrap_q;
    logic [WIDTH-1:0] count_inc;
    logic             at_limit;

    increment #(.WIDTH(WIDTH)) u_increment (
        .a (count),
        .y (count_inc)
    );

    assign at_limit = (count == limit_q);
    assign busy     = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            load_q  <= '0;
            limit_q <= '0;
            wrap_q  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        count   <= load_val;
                        load_q  <= load_val;
                        limit_q <= limit;
                        wrap_q  <= wrap_mode;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // abort wins over both the enable and the terminal count
                    if (abort) begin
                        state <= IDLE;
                    end else if (en) begin
                        if (at_limit) begin
                            done <= 1'b1;
                            if (wrap_q) begin
                                count <= load_q;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            count <= count_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
